// File: rtl/e_mdu_if.sv
// rtl/e_mdu_if.sv - E-stage multiply/divide unit operand, control and result bundle
interface e_mdu_if;
  logic        req;
  logic        start;
  logic [3:0]  mdu_op;
  logic [31:0] E_V1;
  logic [31:0] E_V2;
  logic        busy;
  logic [31:0] mdu_out;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output req, start, mdu_op, E_V1, E_V2,
    input  busy, mdu_out, HI, LO
  );

  modport slave (
    input  req, start, mdu_op, E_V1, E_V2,
    output busy, mdu_out, HI, LO
  );
endinterface

// File: rtl/e_mdu.sv
// rtl/e_mdu.sv - execute-stage mult/div unit owning HI/LO with modelled busy latency
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic   clk,
  input  logic   reset,
  e_mdu_if.slave bus
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic          pend_we_q, pend_we_d;

  logic [31:0] a, b;
  logic [63:0] prod_s, prod_u;
  logic        sdiv, a_neg, b_neg;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;

  assign a = bus.E_V1;
  assign b = bus.E_V2;

  assign prod_u = {32'd0, a} * {32'd0, b};
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};

  // Magnitude divide keeps 0x80000000 / -1 well defined (wraps to 0x80000000, rem 0)
  assign sdiv  = (bus.mdu_op == OP_DIV);
  assign a_neg = sdiv & a[31];
  assign b_neg = sdiv & b[31];
  assign a_mag = a_neg ? (32'd0 - a) : a;
  assign b_mag = b_neg ? (32'd0 - b) : b;
  assign q_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag / b_mag);
  assign r_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag % b_mag);
  assign quot  = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign rem   = a_neg ? (32'd0 - r_mag) : r_mag;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_we_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_we_q <= pend_we_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_we_d = pend_we_q;
    case (state_q)
      S_IDLE: begin
        if (!bus.req) begin
          if (bus.start) begin
            case (bus.mdu_op)
              OP_MULT, OP_MULTU: begin
                {pend_hi_d, pend_lo_d} = (bus.mdu_op == OP_MULT) ? prod_s : prod_u;
                pend_we_d = 1'b1;
                cnt_d     = MULT_LD;
                state_d   = S_BUSY;
              end
              OP_DIV, OP_DIVU: begin
                pend_hi_d = rem;
                pend_lo_d = quot;
                pend_we_d = (b != 32'd0);
                cnt_d     = DIV_LD;
                state_d   = S_BUSY;
              end
              default: ;
            endcase
          end
          if (bus.mdu_op == OP_MTHI) hi_d = a;
          if (bus.mdu_op == OP_MTLO) lo_d = a;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = S_IDLE;
          if (pend_we_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy    = (state_q == S_BUSY);
  assign bus.HI      = hi_q;
  assign bus.LO      = lo_q;
  assign bus.mdu_out = (bus.mdu_op == OP_MFHI) ? hi_q :
                       (bus.mdu_op == OP_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_e_mdu.sv
// tb/tb_e_mdu.sv - scoreboard bench for e_mdu: completion monitor plus directed checks
module tb_e_mdu;
  logic clk;
  logic reset;
  int   nchecks = 0;
  int   nerr    = 0;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;
  exp_t sbq[$];

  e_mdu_if bus();

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input string name, input logic [31:0] hi, input logic [31:0] lo, input int cyc);
    exp_t e;
    e.name = name; e.hi = hi; e.lo = lo; e.cycles = cyc;
    sbq.push_back(e);
  endtask

  task automatic drive(input logic [3:0] op, input logic st, input logic rq,
                       input logic [31:0] a, input logic [31:0] b);
    bus.mdu_op = op; bus.start = st; bus.req = rq; bus.E_V1 = a; bus.E_V2 = b;
    @(posedge clk); #1;
    bus.mdu_op = 4'd0; bus.start = 1'b0; bus.req = 1'b0; bus.E_V1 = '0; bus.E_V2 = '0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (bus.busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_timeout"}, {31'd0, bus.busy}, 32'd0);
  endtask

  // Monitor: every busy fall is a completion; compare HI/LO and busy length
  initial begin
    bit prev_busy = 1'b0;
    int bcnt = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.busy === 1'b1) begin
        bcnt++;
      end else if (prev_busy) begin
        if (sbq.size() == 0) begin
          nchecks++;
          nerr++;
          $display("FAIL unexpected_completion: got HI=%h LO=%h expected none", bus.HI, bus.LO);
        end else begin
          e = sbq.pop_front();
          chk({e.name, "_hi"}, bus.HI, e.hi);
          chk({e.name, "_lo"}, bus.LO, e.lo);
          chk({e.name, "_busy_cycles"}, 32'(bcnt), 32'(e.cycles));
        end
        bcnt = 0;
      end
      prev_busy = (bus.busy === 1'b1);
    end
  end

  initial begin
    reset = 1'b1;
    bus.mdu_op = 4'd0; bus.start = 1'b0; bus.req = 1'b0; bus.E_V1 = '0; bus.E_V2 = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_hi", bus.HI, 32'd0);
    chk("reset_lo", bus.LO, 32'd0);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_mdu_out", bus.mdu_out, 32'd0);

    push("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
    drive(4'd1, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'd3);
    chk("mult_busy_rise", {31'd0, bus.busy}, 32'd1);
    wait_idle("mult");
    bus.mdu_op = 4'd5; #1;
    chk("mfhi", bus.mdu_out, 32'hFFFF_FFFF);
    bus.mdu_op = 4'd6; #1;
    chk("mflo", bus.mdu_out, 32'hFFFF_FFFA);
    bus.mdu_op = 4'd0;

    push("divu_7_2", 32'd1, 32'd3, 10);
    drive(4'd4, 1'b1, 1'b0, 32'd7, 32'd2);
    wait_idle("divu_7_2");

    push("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    drive(4'd3, 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2);
    wait_idle("div_m7_2");

    push("div_ovf", 32'd0, 32'h8000_0000, 10);
    drive(4'd3, 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle("div_ovf");

    drive(4'd7, 1'b0, 1'b0, 32'h1234, 32'd0);
    drive(4'd8, 1'b0, 1'b0, 32'h5678, 32'd0);
    chk("mthi", bus.HI, 32'h1234);
    chk("mtlo", bus.LO, 32'h5678);
    chk("mthi_no_busy", {31'd0, bus.busy}, 32'd0);
    push("div_by_zero", 32'h1234, 32'h5678, 10);
    drive(4'd3, 1'b1, 1'b0, 32'd99, 32'd0);
    wait_idle("div_by_zero");

    drive(4'd1, 1'b1, 1'b1, 32'd5, 32'd5);
    chk("req_mult_busy", {31'd0, bus.busy}, 32'd0);
    chk("req_mult_hi", bus.HI, 32'h1234);
    drive(4'd8, 1'b0, 1'b1, 32'hDEAD, 32'd0);
    chk("req_mtlo_lo", bus.LO, 32'h5678);
    drive(4'd9, 1'b1, 1'b0, 32'd5, 32'd5);
    chk("bad_op_busy", {31'd0, bus.busy}, 32'd0);

    push("mult_req_mid", 32'hFFFF_FFFF, 32'hFFFF_FFF0, 5);
    drive(4'd1, 1'b1, 1'b0, 32'h10, 32'hFFFF_FFFF);
    bus.req = 1'b1;
    repeat (2) @(posedge clk);
    #1 bus.req = 1'b0;
    wait_idle("mult_req_mid");

    push("multu_max", 32'hFFFF_FFFE, 32'd1, 5);
    drive(4'd2, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    drive(4'd7, 1'b0, 1'b0, 32'hAAAA, 32'd0);
    wait_idle("multu_max");
    push("multu_b2b", 32'd0, 32'd15, 5);
    drive(4'd2, 1'b1, 1'b0, 32'd3, 32'd5);
    chk("b2b_busy_rise", {31'd0, bus.busy}, 32'd1);
    bus.mdu_op = 4'd5; #1;
    chk("mfhi_while_busy", bus.mdu_out, 32'hFFFF_FFFE);
    bus.mdu_op = 4'd0;
    wait_idle("multu_b2b");

    push("reset_abort", 32'd0, 32'd0, 4);
    drive(4'd4, 1'b1, 1'b0, 32'd100, 32'd7);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    repeat (12) @(posedge clk);
    #1;
    chk("abort_hi_later", bus.HI, 32'd0);
    chk("abort_lo_later", bus.LO, 32'd0);

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
